// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: frame-latched 4-digit common-anode display multiplexer.
// Define SEG_GHOST_GAP_EN to blank all anodes for GAP_CYCLES after each digit switch.
module seven_seg_scanner #(
    parameter int GAP_CYCLES = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ScanClock,
    input  logic [15:0] Value,
    input  logic [3:0]  DecimalPoints,
    input  logic [3:0]  DigitEnable,
    input  logic        BlankLeadingZeros,
    output logic [3:0]  Anode,
    output logic [6:0]  Cathode,
    output logic        DecimalPoint,
    output logic        FrameStart
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        tick;
    logic        load;
    logic [1:0]  index;
    logic [15:0] sh_value;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_en;
    logic        sh_blz;
    logic [3:0]  nibble;
    logic [3:0]  zero_up;
    logic        dark;
    logic        gap_busy;
    logic [3:0]  an_next;
    logic [6:0]  ca_next;
    logic        dp_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= ScanClock;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;
    // Shadow is refreshed only at frame boundaries so a frame never tears.
    assign load = tick & ((state == IDLE) | (index == 2'd3));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            index      <= 2'd0;
            FrameStart <= 1'b0;
        end else begin
            FrameStart <= load;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        index <= 2'd0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (tick) begin
                        index <= index + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sh_value <= 16'h0000;
            sh_dp    <= 4'h0;
            sh_en    <= 4'h0;
            sh_blz   <= 1'b0;
        end else if (load) begin
            sh_value <= Value;
            sh_dp    <= DecimalPoints;
            sh_en    <= DigitEnable;
            sh_blz   <= BlankLeadingZeros;
        end
    end

    // zero_up[i]: nibbles i..3 are all zero; digit 0 is exempt.
    assign zero_up[3] = (sh_value[15:12] == 4'h0);
    assign zero_up[2] = zero_up[3] & (sh_value[11:8] == 4'h0);
    assign zero_up[1] = zero_up[2] & (sh_value[7:4] == 4'h0);
    assign zero_up[0] = 1'b0;

    assign nibble = sh_value[{index, 2'b00} +: 4];
    assign dark   = (state == IDLE) | ~sh_en[index] | (sh_blz & zero_up[index]);

    always_comb begin
        an_next = 4'hF;
        ca_next = 7'h7F;
        dp_next = 1'b1;
        if (!dark) begin
            an_next = ~(4'b0001 << index);
            ca_next = hex7(nibble);
            dp_next = ~sh_dp[index];
        end
    end

`ifdef SEG_GHOST_GAP_EN
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

    logic [15:0] gap;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            gap <= 16'd0;
        end else if (tick) begin
            gap <= GAP_LOAD;
        end else if (gap != 16'd0) begin
            gap <= gap - 16'd1;
        end
    end

    assign gap_busy = (gap != 16'd0);
`else
    assign gap_busy = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Anode        <= 4'hF;
            Cathode      <= 7'h7F;
            DecimalPoint <= 1'b1;
        end else begin
            Anode        <= gap_busy ? 4'hF : an_next;
            Cathode      <= ca_next;
            DecimalPoint <= dp_next;
        end
    end

endmodule
